muldiv_unit: RTL and testbench

//  Iterative RV32M multiply/divide execution unit; companion to the combinational ALU path.

---
 rtl/riscv_pkg.sv | 41 ++++
 rtl/muldiv_unit_if.sv | 36 +++
 rtl/muldiv_operand_prep.sv | 77 +++++++
 rtl/muldiv_unit.sv | 170 +++++++++++++++++
 tb/tb_muldiv_unit.sv | 205 ++++++++++++++++++++
 5 files changed

// File: rtl/riscv_pkg.sv
`default_nettype none
// ============================================================================
// Package     : riscv_pkg
// Description : Shared RV32 definitions. Holds the M-extension Funct3
//               encodings, the funct7 value that selects M-extension R-type
//               ops, the multiply/divide unit state encoding and op-class
//               helper functions.
// Revision    : 1.0 - initial multiply/divide additions
// ============================================================================
package riscv_pkg;

    localparam logic [6:0] MULDIV_FUNCT7 = 7'b0000001;

    typedef enum logic [2:0] {
        OP_MUL    = 3'b000,
        OP_MULH   = 3'b001,
        OP_MULHSU = 3'b010,
        OP_MULHU  = 3'b011,
        OP_DIV    = 3'b100,
        OP_DIVU   = 3'b101,
        OP_REM    = 3'b110,
        OP_REMU   = 3'b111
    } muldiv_op_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } muldiv_state_e;

    function automatic logic is_div_op(input muldiv_op_e op);
        return op inside {OP_DIV, OP_DIVU, OP_REM, OP_REMU};
    endfunction

    function automatic logic is_rem_op(input muldiv_op_e op);
        return op inside {OP_REM, OP_REMU};
    endfunction

endpackage
`default_nettype wire

// File: rtl/muldiv_unit_if.sv
`default_nettype none
// ============================================================================
// Interface   : muldiv_unit_if
// Description : Request/response bundle of the multiply/divide unit.
//               master : pipeline side (drives request, flush, out_ready)
//               slave  : the unit (drives in_ready, out_valid, Result, busy)
//               Request : in_valid/in_ready, Funct3, SrcA, SrcB
//               Response: out_valid/out_ready, Result
//               Control : flush (abort in-flight op), busy (stall request)
// Revision    : 1.0 - initial release
// ============================================================================
interface muldiv_unit_if #(
    parameter int DATA_W = 32
);
    logic              flush;
    logic              in_valid;
    logic              in_ready;
    logic [2:0]        Funct3;
    logic [DATA_W-1:0] SrcA;
    logic [DATA_W-1:0] SrcB;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] Result;
    logic              busy;

    modport master (
        output flush, in_valid, Funct3, SrcA, SrcB, out_ready,
        input  in_ready, out_valid, Result, busy
    );

    modport slave (
        input  flush, in_valid, Funct3, SrcA, SrcB, out_ready,
        output in_ready, out_valid, Result, busy
    );
endinterface
`default_nettype wire

// File: rtl/muldiv_operand_prep.sv
`default_nettype none
// ============================================================================
// Module      : muldiv_operand_prep
// Description : Combinational operand conditioning for the multiply/divide
//               unit. Produces operand magnitudes per op signedness, the sign
//               to apply to the product/quotient and to the remainder, and
//               the early-out result for divide-by-zero and signed overflow.
//   i_funct3      : operation select
//   i_srca/i_srcb : raw operands
//   o_abs_a/b     : operand magnitudes
//   o_neg_q       : negate product/quotient after iteration
//   o_neg_r       : negate remainder after iteration
//   o_special     : op finishes without iterating
//   o_special_res : result for the early-out case
// Revision    : 1.0 - initial release
// ============================================================================
module muldiv_operand_prep
    import riscv_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  muldiv_op_e        i_funct3,
    input  logic [DATA_W-1:0] i_srca,
    input  logic [DATA_W-1:0] i_srcb,
    output logic [DATA_W-1:0] o_abs_a,
    output logic [DATA_W-1:0] o_abs_b,
    output logic              o_neg_q,
    output logic              o_neg_r,
    output logic              o_special,
    output logic [DATA_W-1:0] o_special_res
);
    localparam logic [DATA_W-1:0] c_min_int = {1'b1, {(DATA_W-1){1'b0}}};

    logic w_signed_a;
    logic w_signed_b;
    logic w_neg_a;
    logic w_neg_b;
    logic w_div_zero;
    logic w_overflow;

    // MUL returns the low half, which is identical for signed and unsigned
    // operands, so it goes through the unsigned path.
    always_comb begin
        w_signed_a = 1'b0;
        w_signed_b = 1'b0;
        case (i_funct3)
            OP_MULH, OP_DIV, OP_REM: begin
                w_signed_a = 1'b1;
                w_signed_b = 1'b1;
            end
            OP_MULHSU: w_signed_a = 1'b1;
            default: ;
        endcase
    end

    assign w_neg_a = w_signed_a & i_srca[DATA_W-1];
    assign w_neg_b = w_signed_b & i_srcb[DATA_W-1];
    assign o_abs_a = w_neg_a ? ({DATA_W{1'b0}} - i_srca) : i_srca;
    assign o_abs_b = w_neg_b ? ({DATA_W{1'b0}} - i_srcb) : i_srcb;
    assign o_neg_q = w_neg_a ^ w_neg_b;
    assign o_neg_r = w_neg_a;

    assign w_div_zero = is_div_op(i_funct3) && (i_srcb == '0);
    assign w_overflow = ((i_funct3 == OP_DIV) || (i_funct3 == OP_REM)) &&
                        (i_srca == c_min_int) && (i_srcb == '1);
    assign o_special  = w_div_zero | w_overflow;

    always_comb begin
        o_special_res = '0;
        if (w_div_zero) begin
            o_special_res = is_rem_op(i_funct3) ? i_srca : '1;
        end else if (w_overflow) begin
            o_special_res = is_rem_op(i_funct3) ? '0 : c_min_int;
        end
    end
endmodule
`default_nettype wire

// File: rtl/muldiv_unit.sv
`default_nettype none
// ============================================================================
// Module      : muldiv_unit
// Description : Iterative RV32M multiply/divide unit. One shift-add (multiply)
//               or restoring shift-subtract (divide) step per cycle for
//               DATA_W cycles, then a sign-fix cycle, then the result is held
//               until the consumer takes it. Divide-by-zero and signed
//               overflow finish in one cycle.
//   clk   : system clock, rising edge
//   reset : asynchronous active-high reset
//   bus   : muldiv_unit_if slave (request, response, flush, busy)
// Revision    : 1.0 - initial release
// ============================================================================
module muldiv_unit
    import riscv_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic         clk,
    input  logic         reset,
    muldiv_unit_if.slave bus
);
    localparam int              CNT_W     = $clog2(DATA_W + 1);
    localparam int              c_acc_w   = 2 * DATA_W + 1;
    localparam logic [CNT_W-1:0] c_last_it = CNT_W'(DATA_W - 1);

    muldiv_state_e      r_state;
    muldiv_state_e      w_next_state;
    muldiv_op_e         r_op;
    logic [c_acc_w-1:0] r_acc;
    logic [DATA_W-1:0]  r_opb;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_neg_q;
    logic               r_neg_r;
    logic [DATA_W-1:0]  r_result;

    logic [DATA_W-1:0]  w_abs_a;
    logic [DATA_W-1:0]  w_abs_b;
    logic               w_neg_q;
    logic               w_neg_r;
    logic               w_special;
    logic [DATA_W-1:0]  w_special_res;
    logic               w_accept;

    muldiv_operand_prep #(
        .DATA_W (DATA_W)
    ) u_prep (
        .i_funct3      (muldiv_op_e'(bus.Funct3)),
        .i_srca        (bus.SrcA),
        .i_srcb        (bus.SrcB),
        .o_abs_a       (w_abs_a),
        .o_abs_b       (w_abs_b),
        .o_neg_q       (w_neg_q),
        .o_neg_r       (w_neg_r),
        .o_special     (w_special),
        .o_special_res (w_special_res)
    );

    // flush beats a simultaneous request
    assign w_accept = (r_state == IDLE) && bus.in_valid && !bus.flush;

    // ---------------- FSM ----------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_state <= IDLE;
        else       r_state <= w_next_state;
    end

    always_comb begin
        w_next_state = r_state;
        if (bus.flush) begin
            w_next_state = IDLE;
        end else begin
            case (r_state)
                IDLE: if (bus.in_valid) w_next_state = w_special ? DONE : CALC;
                CALC: if (r_cnt == c_last_it) w_next_state = FIX;
                FIX:  w_next_state = DONE;
                DONE: if (bus.out_ready) w_next_state = IDLE;
                default: w_next_state = IDLE;
            endcase
        end
    end

    // ---------------- iteration step ----------------
    // Accumulator layout: {spare, high half, low half}. Multiply starts with
    // the multiplier in the low half and shifts it out as the product shifts
    // in; divide starts with the dividend in the low half, shifting quotient
    // bits in at the bottom while the partial remainder builds in the high half.
    logic [DATA_W:0]    w_mul_sum;
    logic [c_acc_w-1:0] w_mul_next;
    logic [DATA_W:0]    w_div_rem;
    logic [DATA_W:0]    w_div_diff;
    logic               w_div_ge;
    logic [c_acc_w-1:0] w_div_next;

    always_comb begin
        w_mul_sum = {1'b0, r_acc[2*DATA_W-1:DATA_W]};
        if (r_acc[0]) w_mul_sum = w_mul_sum + {1'b0, r_opb};
        w_mul_next = {1'b0, w_mul_sum, r_acc[DATA_W-1:1]};

        w_div_rem  = r_acc[2*DATA_W-1:DATA_W-1];
        w_div_diff = w_div_rem - {1'b0, r_opb};
        w_div_ge   = (w_div_rem >= {1'b0, r_opb});
        // the partial remainder stays below the divisor, so DATA_W bits hold it
        w_div_next = {1'b0,
                      w_div_ge ? w_div_diff[DATA_W-1:0] : w_div_rem[DATA_W-1:0],
                      r_acc[DATA_W-2:0], w_div_ge};
    end

    // ---------------- sign fix / half select ----------------
    logic [2*DATA_W-1:0] w_prod;
    logic [DATA_W-1:0]   w_quot;
    logic [DATA_W-1:0]   w_rem;
    logic [DATA_W-1:0]   w_fix_result;

    always_comb begin
        w_prod = r_neg_q ? ({(2*DATA_W){1'b0}} - r_acc[2*DATA_W-1:0])
                         : r_acc[2*DATA_W-1:0];
        w_quot = r_neg_q ? ({DATA_W{1'b0}} - r_acc[DATA_W-1:0]) : r_acc[DATA_W-1:0];
        w_rem  = r_neg_r ? ({DATA_W{1'b0}} - r_acc[2*DATA_W-1:DATA_W])
                         : r_acc[2*DATA_W-1:DATA_W];
        case (r_op)
            OP_MUL:                       w_fix_result = w_prod[DATA_W-1:0];
            OP_MULH, OP_MULHSU, OP_MULHU: w_fix_result = w_prod[2*DATA_W-1:DATA_W];
            OP_DIV, OP_DIVU:              w_fix_result = w_quot;
            default:                      w_fix_result = w_rem;
        endcase
    end

    // ---------------- datapath registers ----------------
    // Nothing here changes in DONE, so a stalled result stays put.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_op     <= OP_MUL;
            r_acc    <= '0;
            r_opb    <= '0;
            r_cnt    <= '0;
            r_neg_q  <= 1'b0;
            r_neg_r  <= 1'b0;
            r_result <= '0;
        end else begin
            case (r_state)
                IDLE: if (w_accept) begin
                    r_op    <= muldiv_op_e'(bus.Funct3);
                    r_acc   <= {{(DATA_W+1){1'b0}}, w_abs_a};
                    r_opb   <= w_abs_b;
                    r_cnt   <= '0;
                    r_neg_q <= w_neg_q;
                    r_neg_r <= w_neg_r;
                    if (w_special) r_result <= w_special_res;
                end
                CALC: if (!bus.flush) begin
                    r_acc <= is_div_op(r_op) ? w_div_next : w_mul_next;
                    r_cnt <= r_cnt + CNT_W'(1);
                end
                FIX: if (!bus.flush) r_result <= w_fix_result;
                default: ;
            endcase
        end
    end

    // spare accumulator bit and subtract borrow carry no information
    logic w_unused;
    assign w_unused = r_acc[c_acc_w-1] ^ w_div_diff[DATA_W];

    assign bus.in_ready  = (r_state == IDLE);
    assign bus.out_valid = (r_state == DONE);
    assign bus.busy      = (r_state != IDLE);
    assign bus.Result    = r_result;
endmodule
`default_nettype wire

// File: tb/tb_muldiv_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_muldiv_unit
// Description : Self-checking bench for muldiv_unit. Directed vectors with
//               hand-computed results and latencies, plus backpressure,
//               flush and asynchronous-reset sequences.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_muldiv_unit;
    typedef struct {
        string       name;
        logic [2:0]  f3;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
        int          lat;
    } vec_t;

    logic clk;
    logic reset;
    int   checks;
    int   failures;
    vec_t vecs[$];

    muldiv_unit_if #(.DATA_W(32)) bus ();

    muldiv_unit #(.DATA_W(32)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic add(input string name, input logic [2:0] f3, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] exp, input int lat);
        vec_t v;
        v.name = name; v.f3 = f3; v.a = a; v.b = b; v.exp = exp; v.lat = lat;
        vecs.push_back(v);
    endtask

    // Issue one op at the current (post-edge) point and leave it sitting in
    // DONE with its result checked. Inputs are scrambled after accept.
    task automatic issue(input vec_t v);
        int lat;
        int w;
        w = 0;
        while (!bus.in_ready && w < 100) begin
            @(posedge clk); #1; w++;
        end
        bus.in_valid = 1'b1;
        bus.Funct3   = v.f3;
        bus.SrcA     = v.a;
        bus.SrcB     = v.b;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        bus.Funct3   = 3'($urandom());
        bus.SrcA     = $urandom();
        bus.SrcB     = $urandom();
        lat = 1;
        while (!bus.out_valid && lat < 100) begin
            @(posedge clk); #1; lat++;
        end
        check({v.name, " latency"}, 32'(lat), 32'(v.lat));
        check({v.name, " result"}, bus.Result, v.exp);
    endtask

    task automatic release_result(input string name);
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
        check({name, " in_ready after take"}, 32'(bus.in_ready), 32'd1);
        check({name, " out_valid after take"}, 32'(bus.out_valid), 32'd0);
    endtask

    task automatic start_op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
        bus.in_valid = 1'b1;
        bus.Funct3   = f3;
        bus.SrcA     = a;
        bus.SrcB     = b;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
    endtask

    initial begin
        vec_t v;
        checks   = 0;
        failures = 0;
        reset         = 1'b1;
        bus.flush     = 1'b0;
        bus.in_valid  = 1'b0;
        bus.Funct3    = 3'b000;
        bus.SrcA      = '0;
        bus.SrcB      = '0;
        bus.out_ready = 1'b0;

        add("MUL 7*-3",         3'b000, 32'd7,          32'hFFFFFFFD, 32'hFFFFFFEB, 34);
        add("MULHU -1*-1",      3'b011, 32'hFFFFFFFF,   32'hFFFFFFFF, 32'hFFFFFFFE, 34);
        add("MULH -1*-1",       3'b001, 32'hFFFFFFFF,   32'hFFFFFFFF, 32'h00000000, 34);
        add("MULHSU -1*max",    3'b010, 32'hFFFFFFFF,   32'hFFFFFFFF, 32'hFFFFFFFF, 34);
        add("MULH min*min",     3'b001, 32'h80000000,   32'h80000000, 32'h40000000, 34);
        add("DIV -7/2",         3'b100, 32'hFFFFFFF9,   32'd2,        32'hFFFFFFFD, 34);
        add("REM -7/2",         3'b110, 32'hFFFFFFF9,   32'd2,        32'hFFFFFFFF, 34);
        add("DIV 7/-2",         3'b100, 32'd7,          32'hFFFFFFFE, 32'hFFFFFFFD, 34);
        add("REM 7/-2",         3'b110, 32'd7,          32'hFFFFFFFE, 32'd1,        34);
        add("DIVU 100/7",       3'b101, 32'd100,        32'd7,        32'd14,       34);
        add("REMU 100/7",       3'b111, 32'd100,        32'd7,        32'd2,        34);
        add("DIVU 100/0",       3'b101, 32'd100,        32'd0,        32'hFFFFFFFF, 1);
        add("REMU 100/0",       3'b111, 32'd100,        32'd0,        32'd100,      1);
        add("DIV 5/0",          3'b100, 32'd5,          32'd0,        32'hFFFFFFFF, 1);
        add("REM -7/0",         3'b110, 32'hFFFFFFF9,   32'd0,        32'hFFFFFFF9, 1);
        add("DIV min/-1",       3'b100, 32'h80000000,   32'hFFFFFFFF, 32'h80000000, 1);
        add("REM min/-1",       3'b110, 32'h80000000,   32'hFFFFFFFF, 32'd0,        1);

        // reset values
        #12;
        check("reset in_ready", 32'(bus.in_ready), 32'd1);
        check("reset out_valid", 32'(bus.out_valid), 32'd0);
        check("reset busy", 32'(bus.busy), 32'd0);
        check("reset Result", bus.Result, 32'd0);
        @(negedge clk); reset = 1'b0;
        @(posedge clk); #1;

        foreach (vecs[i]) begin
            issue(vecs[i]);
            release_result(vecs[i].name);
        end

        // backpressure: result held for 10 cycles
        v.name = "hold DIVU"; v.f3 = 3'b101; v.a = 32'd100; v.b = 32'd7; v.exp = 32'd14; v.lat = 34;
        issue(v);
        for (int k = 0; k < 10; k++) begin
            @(posedge clk); #1;
            check("hold out_valid", 32'(bus.out_valid), 32'd1);
            check("hold Result", bus.Result, 32'd14);
            check("hold in_ready", 32'(bus.in_ready), 32'd0);
        end
        release_result("hold");

        // flush together with a request in IDLE is ignored
        bus.flush = 1'b1;
        start_op(3'b000, 32'd3, 32'd4);
        bus.flush = 1'b0;
        check("flush+req busy", 32'(bus.busy), 32'd0);
        check("flush+req in_ready", 32'(bus.in_ready), 32'd1);

        // flush in CALC cycle 5
        start_op(3'b000, 32'h0000FFFF, 32'h0000FFFF);
        repeat (5) begin @(posedge clk); #1; end
        check("pre-flush busy", 32'(bus.busy), 32'd1);
        bus.flush = 1'b1;
        @(posedge clk); #1;
        bus.flush = 1'b0;
        check("flush in_ready", 32'(bus.in_ready), 32'd1);
        check("flush busy", 32'(bus.busy), 32'd0);
        begin
            int seen;
            seen = 0;
            repeat (40) begin
                @(posedge clk); #1;
                if (bus.out_valid) seen = 1;
            end
            check("flush no out_valid", 32'(seen), 32'd0);
        end
        v.name = "post-flush MUL 3*4"; v.f3 = 3'b000; v.a = 32'd3; v.b = 32'd4; v.exp = 32'd12; v.lat = 34;
        issue(v);
        release_result(v.name);

        // async reset mid-CALC
        start_op(3'b001, 32'h12345678, 32'h9ABCDEF0);
        repeat (5) begin @(posedge clk); #1; end
        #2 reset = 1'b1;
        #1;
        check("async rst in_ready", 32'(bus.in_ready), 32'd1);
        check("async rst busy", 32'(bus.busy), 32'd0);
        check("async rst out_valid", 32'(bus.out_valid), 32'd0);
        check("async rst Result", bus.Result, 32'd0);
        @(negedge clk); reset = 1'b0;
        @(posedge clk); #1;
        check("post-rst out_valid", 32'(bus.out_valid), 32'd0);
        check("post-rst busy", 32'(bus.busy), 32'd0);
        v.name = "post-reset MUL 3*4";
        issue(v);
        release_result(v.name);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end
endmodule
`default_nettype wire
